// File: rtl/ghash_block_packer.sv
// Packs a per-message stream of AAD/ciphertext blocks into N_BLOCKS-wide GHASH words
// and appends the {len(A), len(C)} length block, with sop/eop/skip framing.
module ghash_block_packer #(
    parameter int unsigned NB_BLOCK  = 128,
    parameter int unsigned N_BLOCKS  = 2,
    parameter int unsigned NB_DATA   = NB_BLOCK * N_BLOCKS,
    parameter int unsigned NB_NBYTES = 5
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [NB_BLOCK-1:0]  i_block,
    input  logic [NB_NBYTES-1:0] i_nbytes,
    input  logic                 i_is_aad,
    input  logic                 i_last,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [NB_DATA-1:0]   o_data_x_bus,
    output logic                 o_valid,
    output logic                 o_sop,
    output logic                 o_eop,
    output logic [N_BLOCKS-1:0]  o_skip_bus
);

    localparam int unsigned SlotW  = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
    localparam int unsigned NBytes = NB_BLOCK / 8;
    localparam logic [SlotW-1:0] LastSlot = SlotW'(N_BLOCKS - 1);

    typedef enum logic [1:0] {StIdle, StPack, StLen} state_t;

    state_t state_q, state_d;
    logic [N_BLOCKS-1:0][NB_BLOCK-1:0] buf_q, buf_d, word;
    logic [SlotW-1:0]    slot_q, slot_d;
    logic [63:0]         len_a_q, len_a_d, len_c_q, len_c_d;
    logic                sop_pend_q, sop_pend_d;
    logic                ready_q;
    logic [NB_DATA-1:0]  data_q, data_d;
    logic                valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic [N_BLOCKS-1:0] skip_q, skip_d;
    logic                accept;
    logic [NB_BLOCK-1:0] masked;
    logic [63:0]         add_bits;

    assign accept   = i_valid && ready_q;
    assign add_bits = 64'(i_nbytes) << 3;

    // Byte 0 sits at the MSBs, so trailing invalid bytes are the low-order ones.
    always_comb begin
        masked = '0;
        for (int i = 0; i < NBytes; i++) begin
            if (i < int'(i_nbytes)) begin
                masked[NB_BLOCK-1-8*i -: 8] = i_block[NB_BLOCK-1-8*i -: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        slot_d     = slot_q;
        len_a_d    = len_a_q;
        len_c_d    = len_c_q;
        sop_pend_d = sop_pend_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        skip_d     = '0;
        word       = buf_q;
        unique case (state_q)
            StIdle, StPack: begin
                if (accept) begin
                    if (state_q == StIdle) begin
                        sop_pend_d = 1'b1;
                    end
                    if (i_nbytes != '0) begin
                        buf_d[slot_q] = masked;
                        if (i_is_aad) begin
                            len_a_d = len_a_q + add_bits;
                        end else begin
                            len_c_d = len_c_q + add_bits;
                        end
                        if (slot_q == LastSlot) begin
                            data_d     = buf_d;
                            valid_d    = 1'b1;
                            sop_d      = sop_pend_d;
                            sop_pend_d = 1'b0;
                            buf_d      = '0;
                            slot_d     = '0;
                        end else begin
                            slot_d = slot_q + 1'b1;
                        end
                    end
                    state_d = i_last ? StLen : StPack;
                end
            end
            StLen: begin
                // Slots above slot_q are already zero because the buffer fills in order.
                word[slot_q] = {len_a_q, len_c_q};
                data_d       = word;
                for (int k = 0; k < N_BLOCKS; k++) begin
                    skip_d[k] = (k > int'(slot_q));
                end
                valid_d    = 1'b1;
                eop_d      = 1'b1;
                sop_d      = sop_pend_q;
                sop_pend_d = 1'b0;
                buf_d      = '0;
                slot_d     = '0;
                len_a_d    = '0;
                len_c_d    = '0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= StIdle;
            buf_q      <= '0;
            slot_q     <= '0;
            len_a_q    <= '0;
            len_c_q    <= '0;
            sop_pend_q <= 1'b0;
            ready_q    <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            skip_q     <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            slot_q     <= slot_d;
            len_a_q    <= len_a_d;
            len_c_q    <= len_c_d;
            sop_pend_q <= sop_pend_d;
            ready_q    <= (state_d != StLen);
            data_q     <= data_d;
            valid_q    <= valid_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            skip_q     <= skip_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_data_x_bus = data_q;
    assign o_valid      = valid_q;
    assign o_sop        = sop_q;
    assign o_eop        = eop_q;
    assign o_skip_bus   = skip_q;

endmodule

// File: tb/tb_ghash_block_packer.sv
// Scoreboard bench for ghash_block_packer: a 2-slot and a 4-slot instance share the
// input block fields; expected words are queued per instance and checked by monitors.
module tb_ghash_block_packer;

    typedef struct packed {
        logic [255:0] data;
        logic         sop;
        logic         eop;
        logic [1:0]   skip;
    } exp2_t;

    typedef struct packed {
        logic [511:0] data;
        logic         sop;
        logic         eop;
        logic [3:0]   skip;
    } exp4_t;

    localparam logic [127:0] A1 = 128'hfeedfacedeadbeeffeedfacedeadbeef;
    localparam logic [127:0] A2 = {32'habaddad2, {96{1'b1}}};
    localparam logic [127:0] A2M = {32'habaddad2, 96'h0};
    localparam logic [127:0] C1 = 128'h42831ec2217774244b7221b784d0d49c;
    localparam logic [127:0] C2 = 128'he3aa212f2c02a4e035c17e2329aca12e;
    localparam logic [127:0] C3 = 128'h21d514b25466931c7d8f6a5aac84aa05;
    localparam logic [127:0] C4 = {96'h1ba30b396a0aac973d58e091, 32'hffffffff};
    localparam logic [127:0] C4M = 128'h1ba30b396a0aac973d58e09100000000;
    localparam logic [127:0] T2 = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] X = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] Y = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] Z = 128'hcafebabe0123456789abcdef55aa55aa;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] blk;
    logic [4:0]   nb;
    logic         aad, last, valid2, valid4;
    logic         rdy2, ov2, sop2, eop2, rdy4, ov4, sop4, eop4;
    logic [255:0] data2;
    logic [511:0] data4;
    logic [1:0]   skip2;
    logic [3:0]   skip4;

    int checks = 0;
    int errors = 0;
    int ready_low = 0;
    logic count_en = 1'b0;
    exp2_t q2[$];
    exp4_t q4[$];

    always #5 clk = ~clk;

    ghash_block_packer #(.NB_BLOCK(128), .N_BLOCKS(2), .NB_DATA(256), .NB_NBYTES(5)) dut2 (
        .i_clock(clk), .i_reset(rst), .i_block(blk), .i_nbytes(nb), .i_is_aad(aad),
        .i_last(last), .i_valid(valid2), .o_ready(rdy2), .o_data_x_bus(data2),
        .o_valid(ov2), .o_sop(sop2), .o_eop(eop2), .o_skip_bus(skip2)
    );

    ghash_block_packer #(.NB_BLOCK(128), .N_BLOCKS(4), .NB_DATA(512), .NB_NBYTES(5)) dut4 (
        .i_clock(clk), .i_reset(rst), .i_block(blk), .i_nbytes(nb), .i_is_aad(aad),
        .i_last(last), .i_valid(valid4), .o_ready(rdy4), .o_data_x_bus(data4),
        .o_valid(ov4), .o_sop(sop4), .o_eop(eop4), .o_skip_bus(skip4)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (count_en && !rdy2) ready_low++;
            if (ov2) begin
                checks++;
                if (q2.size() == 0) begin
                    errors++;
                    $display("FAIL word2_unexpected got %h sop %b eop %b skip %b want none",
                             data2, sop2, eop2, skip2);
                end else begin
                    exp2_t e;
                    e = q2.pop_front();
                    if ({data2, sop2, eop2, skip2} !== e) begin
                        errors++;
                        $display("FAIL word2 got %h sop %b eop %b skip %b want %h sop %b eop %b skip %b",
                                 data2, sop2, eop2, skip2, e.data, e.sop, e.eop, e.skip);
                    end
                end
            end else if (sop2 || eop2 || skip2 != 2'b00) begin
                checks++;
                errors++;
                $display("FAIL pulse2 got sop %b eop %b skip %b want 0 without valid",
                         sop2, eop2, skip2);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov4) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL word4_unexpected got %h want none", data4);
            end else begin
                exp4_t e;
                e = q4.pop_front();
                if ({data4, sop4, eop4, skip4} !== e) begin
                    errors++;
                    $display("FAIL word4 got %h sop %b eop %b skip %b want %h sop %b eop %b skip %b",
                             data4, sop4, eop4, skip4, e.data, e.sop, e.eop, e.skip);
                end
            end
        end
    end

    task automatic push2(input logic [255:0] d, input logic s, input logic e, input logic [1:0] k);
        exp2_t t;
        t.data = d; t.sop = s; t.eop = e; t.skip = k;
        q2.push_back(t);
    endtask

    task automatic push4(input logic [511:0] d, input logic s, input logic e, input logic [3:0] k);
        exp4_t t;
        t.data = d; t.sop = s; t.eop = e; t.skip = k;
        q4.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat transfers.
    task automatic beat(input bit sel4, input logic [127:0] b, input logic [4:0] n,
                        input logic a, input logic l);
        int guard = 0;
        blk = b; nb = n; aad = a; last = l;
        valid2 = !sel4; valid4 = sel4;
        while (!(sel4 ? rdy4 : rdy2)) begin
            @(negedge clk);
            guard++;
            if (guard > 10) begin
                $display("FAIL ready_timeout got ready 0 want 1");
                errors++;
                checks++;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        valid2 = 1'b0; valid4 = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((q2.size() != 0 || q4.size() != 0) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", 64'(q2.size() + q4.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        check(name, 64'({rdy2, ov2, sop2, eop2, skip2, rdy4, ov4, sop4, eop4, skip4}), 64'd0);
        check({name, "_data"}, 64'(|{data2, data4}), 64'd0);
    endtask

    initial begin
        rst = 1'b1; blk = '0; nb = '0; aad = 1'b0; last = 1'b0;
        valid2 = 1'b0; valid4 = 1'b0;
        #1 check_zero("reset_outputs");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 check("ready_before_edge", 64'(rdy2), 64'd0);
        @(negedge clk);
        check("ready_after_edge", 64'(rdy2), 64'd1);

        // GCM test case 4.
        push2({A2M, A1}, 1'b1, 1'b0, 2'b00);
        push2({C2, C1}, 1'b0, 1'b0, 2'b00);
        push2({C4M, C3}, 1'b0, 1'b0, 2'b00);
        push2({128'h0, 64'ha0, 64'h1e0}, 1'b0, 1'b1, 2'b10);
        beat(0, A1, 5'd16, 1'b1, 1'b0);
        beat(0, A2, 5'd4, 1'b1, 1'b0);
        beat(0, C1, 5'd16, 1'b0, 1'b0);
        beat(0, C2, 5'd16, 1'b0, 1'b0);
        beat(0, C3, 5'd16, 1'b0, 1'b0);
        beat(0, C4, 5'd12, 1'b0, 1'b1);
        idle();
        drain();

        // Single ciphertext block, 2-cycle latency.
        push2({64'h0, 64'h80, T2}, 1'b1, 1'b1, 2'b00);
        beat(0, T2, 5'd16, 1'b0, 1'b1);
        idle();
        check("t2_lat1_valid", 64'(ov2), 64'd0);
        @(negedge clk);
        check("t2_lat2_valid", 64'(ov2), 64'd1);
        drain();

        // Empty message.
        push2(256'h0, 1'b1, 1'b1, 2'b10);
        beat(0, Z, 5'd0, 1'b0, 1'b1);
        idle();
        drain();

        // Back-to-back messages with valid held high.
        push2({Y, X}, 1'b1, 1'b0, 2'b00);
        push2({128'h0, 64'h80, 64'h80}, 1'b0, 1'b1, 2'b10);
        push2({64'h0, 64'h80, T2}, 1'b1, 1'b1, 2'b00);
        ready_low = 0;
        count_en = 1'b1;
        beat(0, X, 5'd16, 1'b1, 1'b0);
        beat(0, Y, 5'd16, 1'b0, 1'b1);
        beat(0, T2, 5'd16, 1'b0, 1'b1);
        idle();
        drain();
        count_en = 1'b0;
        check("b2b_ready_low_cycles", 64'(ready_low), 64'd2);

        // Reset mid-message.
        push2({Y, X}, 1'b1, 1'b0, 2'b00);
        beat(0, X, 5'd16, 1'b1, 1'b0);
        beat(0, Y, 5'd16, 1'b1, 1'b0);
        beat(0, Z, 5'd16, 1'b1, 1'b0);
        idle();
        rst = 1'b1;
        #1 check_zero("midreset_outputs");
        check("midreset_pending", 64'(q2.size()), 64'd0);
        repeat (2) @(negedge clk);
        check_zero("midreset_hold");
        rst = 1'b0;
        push2({64'h0, 64'h80, T2}, 1'b1, 1'b1, 2'b00);
        beat(0, T2, 5'd16, 1'b0, 1'b1);
        idle();
        drain();

        // Four-slot instance, five full AAD blocks.
        push4({Z, Y, X, A1}, 1'b1, 1'b0, 4'b0000);
        push4({256'h0, 64'd640, 64'd0, C1}, 1'b0, 1'b1, 4'b1100);
        beat(1, A1, 5'd16, 1'b1, 1'b0);
        beat(1, X, 5'd16, 1'b1, 1'b0);
        beat(1, Y, 5'd16, 1'b1, 1'b0);
        beat(1, Z, 5'd16, 1'b1, 1'b0);
        beat(1, C1, 5'd16, 1'b1, 1'b1);
        idle();
        drain();

        check("queues_empty", 64'(q2.size() + q4.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ghash_block_packer.md
Name: ghash_block_packer

Overview:
- Transmit-side formatter for ghash_n_blocks: converts a per-message stream of 128-bit AAD and ciphertext blocks into the multi-block GHASH input bus.
- Zero-pads partial blocks and packs blocks contiguously into N_BLOCKS slots, slot 0 at the LSBs.
- After the last data block it appends the GCM length block {len(A), len(C)} in bits.
- Drives data bus, sop, valid and per-slot skip flags so the GHASH core needs no further framing.

Parameters:
NB_BLOCK, 128, block width; only 128 supported.
N_BLOCKS, 2, slots per output word; must be >= 2.
NB_DATA, NB_BLOCK*N_BLOCKS, output bus width.
NB_NBYTES, 5, width of valid-byte count.

Ports:
i_clock  in  1  clock, rising edge.
i_reset  in  1  asynchronous, active-high reset.
i_block  in  NB_BLOCK  input block, byte 0 = bits [127:120].
i_nbytes  in  NB_NBYTES  valid bytes in i_block, range 0..16.
i_is_aad  in  1  1 = AAD block, 0 = ciphertext block.
i_last  in  1  final block of the message.
i_valid  in  1  input beat valid.
o_ready  out  1  packer accepts a beat; a beat transfers when i_valid && o_ready.
o_data_x_bus  out  NB_DATA  packed word; slot k = bits [k*128 +: 128].
o_valid  out  1  o_data_x_bus valid this cycle; drives GHASH i_valid.
o_sop  out  1  first word of a message.
o_eop  out  1  word carrying the length block.
o_skip_bus  out  N_BLOCKS  bit k = 1 means slot k is unused and must be skipped.

Behaviour:
- Reset, asynchronous: all outputs 0, including o_ready. Slot buffer, slot index and length counters cleared; state IDLE. o_ready = 1 from the first clock edge after reset deasserts.
- States:
  - IDLE: no message open. o_ready = 1. An accepted beat opens the message; next state is PACK, or LEN if i_last = 1.
  - PACK: o_ready = 1. Accepts blocks; an accepted beat with i_last = 1 moves to LEN.
  - LEN: o_ready = 0 for exactly one cycle. Length block inserted; next state IDLE.
- Masking: bytes at index >= i_nbytes are forced to 0 before storing. Only the final AAD block and the final ciphertext block may be partial; the sender guarantees this and the packer does not check it.
- i_nbytes = 0 is legal only with i_last = 1. No slot is consumed and the counters are unchanged, which supports empty messages.
- Counters: len_a += 8*i_nbytes on AAD beats; len_c += 8*i_nbytes on ciphertext beats. Both 64-bit, wrap mod 2^64. The length block is {len_a, len_c}.
- Packing: each stored block is written to the current slot and the slot index increments.
  - When a block fills slot N_BLOCKS-1, the word is emitted on the next cycle. Latency is 1 cycle from acceptance to o_valid. The slot index wraps to 0 and the buffer clears.
- LEN cycle (registered output at the edge that ends LEN):
  - The length block goes into the current slot index, always < N_BLOCKS.
  - Emitted with o_valid = 1 and o_eop = 1.
  - o_skip_bus has bit k = 1 for every slot above the length slot; those slots are 0.
- If the last data block filled a word, that word is emitted with o_eop = 0, immediately followed by the length word, which has the length block in slot 0.
- o_sop = 1 on the first emitted word of each message. Sop and eop are both 1 when the message fits in one word.
- o_skip_bus = 0 on all non-eop words.
- o_valid, o_sop, o_eop and o_skip_bus are single-cycle pulses. o_data_x_bus holds its value between words.
- Back-to-back messages: a new first beat can be accepted in the cycle after LEN; the IDLE-entry cycle has o_ready = 1.
- Reset mid-message: the partial message is discarded and no o_valid is produced until a new message completes a word.

Test Plan:
1. GCM test case 4.
   - Stimulus: AAD feedfacedeadbeeffeedfacedeadbeef (16 B), abaddad2 followed by 0xFF junk (4 B). Ciphertext 42831ec2…d49c, e3aa…a12e, 21d5…aa05, 1ba30b39…3d58e091 followed by junk (12 B), last = 1.
   - Required response, 4 words:
     - Word 0: {abaddad2 followed by 0s, feedface…beef}, sop = 1.
     - Word 1: {e3aa…, 4283…}.
     - Word 2: {1ba30b396a0aac973d58e09100000000, 21d5…}.
     - Word 3: {0, 000…00a0_000…01e0}, skip = 2'b10, eop = 1.
   - End-to-end with ghash_n_blocks and H = b83b…3b78 gives 698e57f70e6ecc7fd9463b7260a9ae5f.
2. Single ciphertext block 0388dace60b6a392f328c2b971b2fe78, 16 B, last = 1, no AAD -> one word {64'h0, 64'h80, C}, skip = 00, sop = eop = 1, latency 2 cycles from acceptance.
3. Empty message: one beat, nbytes = 0, last = 1 -> one word, slot 0 = 0, skip = 2'b10, sop = eop = 1.
4. Two back-to-back messages with i_valid held high -> o_ready low exactly one cycle per message; the beat held during o_ready = 0 is not lost or duplicated; the second message's first word has sop = 1.
5. Reset asserted after 3 beats of a message, then a fresh test-2 message -> all outputs 0 during reset and the only output is the test-2 word.
6. N_BLOCKS = 4, 5 AAD blocks of 16 B -> word 0 has 4 blocks; word 1 = {0, 0, length {640, 0}, block 4}, skip = 4'b1100.
